lsu_ctrl: RTL and testbench
===========================

LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 Parameters: none; the single feature option is the macro in Configuration.
REQ-002 clk  in  1  single clock; all state updates on posedge clk.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 req_valid  in  1  upstream load/store request present.
REQ-005 req_ready  out  1  lsu_ctrl accepts a request; high only in IDLE.
REQ-006 req_we  in  1  1 = store (sd), 0 = load (ld).
REQ-007 req_addr  in  64  byte address.
REQ-008 req_wdata  in  64  store data.
REQ-009 req_rd  in  5  destination register tag, returned with the response.
REQ-010 mem_address  out  64  to data memory address.
REQ-011 mem_write_data  out  64  to data memory write_data.
REQ-012 MemRead, MemWrite  out  1 each  to data memory strobes.
REQ-013 mem_read_data  in  64  from data memory read_data; registered, valid the cycle after the MemRead edge.
REQ-014 resp_valid  out  1  response present.
REQ-015 resp_ready  in  1  downstream consumes response.
REQ-016 resp_rdata  out  64  load data; 0 for stores and errors.
REQ-017 resp_rd  out  5  tag of the completed request.
REQ-018 resp_err  out  1  request rejected, no memory access performed.
REQ-019 err_count  out  16  saturating count of rejected requests.

Function
REQ-020 FSM states IDLE, ISSUE, WAIT, RESP; acceptance at edge E0 when state=IDLE and req_valid=1; request fields are latched at E0.
REQ-021 Bound check: req_addr > 1016 is an error (an 8-byte access must not wrap the 1 KB array).
REQ-022 Error path: IDLE->RESP at E0; resp_valid from the cycle after E0; resp_err=1, resp_rdata=0; MemRead and MemWrite are never asserted; err_count increments unless it equals 0xFFFF.
REQ-023 Store path: IDLE->ISSUE at E0; ISSUE is one cycle with MemWrite=1 and mem_address/mem_write_data driven from the latched fields; ISSUE->RESP at E1; resp_valid from the cycle after E1.
REQ-024 Load path: IDLE->ISSUE at E0; ISSUE has MemRead=1; ISSUE->WAIT at E1; mem_read_data is captured into resp_rdata at E2; WAIT->RESP at E2.
REQ-025 MemRead and MemWrite are asserted only in ISSUE, for exactly one cycle, and never together.
REQ-026 RESP holds resp_valid, resp_rdata, resp_rd and resp_err stable until resp_valid and resp_ready are both high at an edge; RESP->IDLE at that edge.
REQ-027 A new request is accepted no earlier than the cycle after the response handshake; there is no back-to-back overlap.
REQ-028 mem_address and mem_write_data are 0 outside ISSUE and WAIT.

Reset
REQ-029 Asynchronous reset forces IDLE and sets every output to 0, including err_count; req_ready becomes 1 on the first cycle after reset deasserts.
REQ-030 Reset asserted during ISSUE drops MemWrite/MemRead immediately; the in-flight request is discarded and produces no response.

Configuration
REQ-031 LSU_MISALIGN_TRAP_EN defined: req_addr[2:0] != 0 is an additional error, handled per REQ-022.
REQ-032 LSU_MISALIGN_TRAP_EN undefined: misaligned addresses are issued to memory unchanged; only the bound check applies.

Verification
REQ-033 Store addr=0x10, wdata=0x1122334455667788 -> MemWrite=1 for one cycle, resp_valid=1 the cycle after ISSUE, resp_err=0, resp_rdata=0.
REQ-034 Load addr=0x10 after the REQ-033 store -> MemRead=1 for one cycle, resp_rdata=0x1122334455667788 three cycles after acceptance, resp_rd echoed.
REQ-035 Load addr=0x3F9 -> resp_err=1 the cycle after acceptance, no strobes, err_count=1; hold 0xFFFF and issue another error -> err_count stays 0xFFFF.
REQ-036 Load addr=0x13 -> with the macro: resp_err=1; without the macro: memory is read and resp_err=0.
REQ-037 resp_ready=0 for 5 cycles -> response fields stable and req_ready=0 throughout; assert resp_ready -> IDLE the next cycle.
REQ-038 Assert reset in the ISSUE cycle of a store -> MemWrite=0 immediately, no response, memory location unchanged.

Source files
------------

// File: rtl/lsu_ctrl.sv
// Load/store controller: accepts one ld/sd request at a time, bound-checks it against a 1 KB data memory and returns one response.
// Build option: define LSU_MISALIGN_TRAP_EN to also reject addresses that are not 8-byte aligned.
module lsu_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    input  logic [4:0]  req_rd,
    output logic [63:0] mem_address,
    output logic [63:0] mem_write_data,
    output logic        MemRead,
    output logic        MemWrite,
    input  logic [63:0] mem_read_data,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic [4:0]  resp_rd,
    output logic        resp_err,
    output logic [15:0] err_count,
    output logic [1:0]  dbg_state
);

    // Handshakes: a transfer happens at a posedge where valid and ready are both high;
    // valid never waits for ready, and the payload is held stable while valid is high.

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        accept;
    logic        req_bad;
    logic        lat_we;
    logic [63:0] lat_addr;
    logic [63:0] lat_wdata;

    assign accept = req_valid && req_ready;

    // The last legal 8-byte access starts at 1016, so it ends on byte 1023.
    always_comb begin
        req_bad = (req_addr > 64'd1016);
`ifdef LSU_MISALIGN_TRAP_EN
        req_bad = req_bad || (req_addr[2:0] != 3'b000);
`else
        req_bad = req_bad;
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nxt = req_bad ? S_RESP : S_ISSUE;
                end
            end
            S_ISSUE: state_nxt = lat_we ? S_RESP : S_WAIT;
            S_WAIT:  state_nxt = S_RESP;
            S_RESP: begin
                if (resp_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lat_we     <= 1'b0;
            lat_addr   <= 64'd0;
            lat_wdata  <= 64'd0;
            resp_rdata <= 64'd0;
            resp_rd    <= 5'd0;
            resp_err   <= 1'b0;
            err_count  <= 16'd0;
        end else begin
            if (state == S_IDLE && accept) begin
                lat_we     <= req_we;
                lat_addr   <= req_addr;
                lat_wdata  <= req_wdata;
                resp_rdata <= 64'd0;
                resp_rd    <= req_rd;
                resp_err   <= req_bad;
                if (req_bad && err_count != 16'hFFFF) begin
                    err_count <= err_count + 16'd1;
                end
            end
            // Memory read data is registered, so it is valid during WAIT.
            if (state == S_WAIT) begin
                resp_rdata <= mem_read_data;
            end
        end
    end

    // reset gates req_ready so it reads 0 while reset is held.
    always_comb begin
        req_ready      = (state == S_IDLE) && !reset;
        MemWrite       = (state == S_ISSUE) && lat_we;
        MemRead        = (state == S_ISSUE) && !lat_we;
        resp_valid     = (state == S_RESP);
        mem_address    = 64'd0;
        mem_write_data = 64'd0;
        if (state == S_ISSUE || state == S_WAIT) begin
            mem_address    = lat_addr;
            mem_write_data = lat_wdata;
        end
        dbg_state = state;
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Randomized bench for lsu_ctrl: a byte-array data memory, a request-level reference model and a response scoreboard.
module tb_lsu_ctrl;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic [4:0]  req_rd;
    logic [63:0] mem_address;
    logic [63:0] mem_write_data;
    logic        MemRead;
    logic        MemWrite;
    logic [63:0] mem_read_data;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_rdata;
    logic [4:0]  resp_rd;
    logic        resp_err;
    logic [15:0] err_count;
    logic [1:0]  dbg_state;

    lsu_ctrl dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
        .mem_address(mem_address), .mem_write_data(mem_write_data),
        .MemRead(MemRead), .MemWrite(MemWrite), .mem_read_data(mem_read_data),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .resp_rd(resp_rd), .resp_err(resp_err), .err_count(err_count),
        .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- data memory (environment) ----------------
    logic [7:0] dmem [0:1023];
    int         n_rd_strobe;
    int         n_wr_strobe;
    logic       both_seen;

    initial begin
        for (int i = 0; i < 1024; i++) dmem[i] = 8'h00;
        mem_read_data = 64'd0;
        n_rd_strobe   = 0;
        n_wr_strobe   = 0;
        both_seen     = 1'b0;
    end

    always @(posedge clk) begin
        if (MemRead && MemWrite) both_seen <= 1'b1;
        if (MemRead) begin
            n_rd_strobe <= n_rd_strobe + 1;
            for (int i = 0; i < 8; i++)
                mem_read_data[i*8 +: 8] <= dmem[(mem_address[9:0] + 10'(i))];
        end
        if (MemWrite) begin
            n_wr_strobe <= n_wr_strobe + 1;
            for (int i = 0; i < 8; i++)
                dmem[(mem_address[9:0] + 10'(i))] <= mem_write_data[i*8 +: 8];
        end
    end

    // ---------------- reference model + scoreboard ----------------
    logic [7:0]  ref_mem [0:1023];
    logic [15:0] ref_err_count;
    logic [63:0] exp_q [$];
    int          n_vec;
    int          n_bad;

    initial begin
        for (int i = 0; i < 1024; i++) ref_mem[i] = 8'h00;
        ref_err_count = 16'd0;
        n_vec = 0;
        n_bad = 0;
    end

    task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic model_is_error(input logic [63:0] addr);
        logic bad;
        bad = (addr > 64'd1016);
`ifdef LSU_MISALIGN_TRAP_EN
        if (addr % 8 != 0) bad = 1'b1;
`endif
        return bad;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic wait_ready();
        int n;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) check("req_ready_timeout", 72'(req_ready), 72'd1);
    endtask

    task automatic run_req(input logic we, input logic [63:0] addr, input logic [63:0] wdata,
                           input logic [4:0] rd, input int hold);
        logic        bad;
        int          exp_lat;
        int          exp_rds;
        int          exp_wrs;
        int          rd0;
        int          wr0;
        int          lat;
        logic [63:0] exp_rdata;
        logic [71:0] snap;

        bad = model_is_error(addr);
        exp_rdata = 64'd0;
        exp_rds = 0;
        exp_wrs = 0;
        if (bad) begin
            exp_lat = 1;
            if (ref_err_count != 16'hFFFF) ref_err_count = ref_err_count + 16'd1;
        end else if (we) begin
            exp_lat = 2;
            exp_wrs = 1;
            for (int i = 0; i < 8; i++) ref_mem[int'(addr) + i] = wdata[i*8 +: 8];
        end else begin
            exp_lat = 3;
            exp_rds = 1;
            for (int i = 0; i < 8; i++) exp_rdata[i*8 +: 8] = ref_mem[int'(addr) + i];
        end
        exp_q.push_back(exp_rdata);

        wait_ready();
        rd0 = n_rd_strobe;
        wr0 = n_wr_strobe;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_rd    = rd;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        req_addr  = {$urandom, $urandom};
        lat = 1;
        while (!resp_valid && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        check("resp_latency", 72'(lat), 72'(exp_lat));
        check("resp_err", 72'(resp_err), 72'(bad));
        check("resp_rdata", 72'(resp_rdata), 72'(exp_q.pop_front()));
        check("resp_rd", 72'(resp_rd), 72'(rd));
        check("read_strobes", 72'(n_rd_strobe - rd0), 72'(exp_rds));
        check("write_strobes", 72'(n_wr_strobe - wr0), 72'(exp_wrs));
        check("err_count", 72'(err_count), 72'(ref_err_count));
        check("mem_address_idle", 72'(mem_address), 72'd0);
        check("req_ready_in_resp", 72'(req_ready), 72'd0);

        snap = {2'b0, resp_err, resp_rd, resp_rdata};
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("resp_stable", {2'b0, resp_err, resp_rd, resp_rdata}, snap);
            check("resp_valid_held", 72'({resp_valid, req_ready}), 72'b10);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        check("idle_after_handshake", 72'({resp_valid, req_ready}), 72'b01);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [63:0] a;
        logic [63:0] rnd_addr;
        int          rd0;
        int          wr0;

        reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = 64'd0;
        req_wdata = 64'd0; req_rd = 5'd0; resp_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs",
              72'({req_ready, MemRead, MemWrite, resp_valid, resp_err, resp_rd, err_count}), 72'd0);
        check("reset_rdata_addr", 72'(resp_rdata | mem_address | mem_write_data), 72'd0);
        reset = 1'b0;
        @(negedge clk);
        check("req_ready_after_reset", 72'(req_ready), 72'd1);

        // directed: store, load back, bound error
        run_req(1'b1, 64'h10, 64'h1122334455667788, 5'd3, 0);
        run_req(1'b0, 64'h10, 64'd0, 5'd7, 0);
        run_req(1'b0, 64'h3F9, 64'd0, 5'd9, 0);
        run_req(1'b0, 64'd1016, 64'd0, 5'd10, 0);
        run_req(1'b0, 64'd1017, 64'd0, 5'd11, 0);
        // misaligned: error with the trap option, plain read without
        run_req(1'b0, 64'h13, 64'd0, 5'd12, 0);
        // backpressure: response held for 5 cycles
        run_req(1'b0, 64'h10, 64'd0, 5'd13, 5);

        // randomized traffic
        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 3))
                0: rnd_addr = 64'($urandom_range(0, 127)) * 8;
                1: rnd_addr = 64'($urandom_range(0, 1016));
                2: rnd_addr = 64'($urandom_range(1017, 1100));
                default: rnd_addr = {$urandom, $urandom};
            endcase
            run_req(1'($urandom_range(0, 1)), rnd_addr, {$urandom, $urandom},
                    5'($urandom_range(0, 31)), $urandom_range(0, 3));
        end

        // reset during ISSUE of a store: write dropped, no response
        a = 64'h40;
        wait_ready();
        rd0 = n_rd_strobe;
        wr0 = n_wr_strobe;
        req_valid = 1'b1; req_we = 1'b1; req_addr = a;
        req_wdata = 64'hDEADBEEFCAFEF00D; req_rd = 5'd21;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check("store_issue_strobe", 72'(MemWrite), 72'd1);
        reset = 1'b1;
        #1;
        check("reset_drops_memwrite", 72'({MemWrite, MemRead}), 72'd0);
        check("reset_no_resp", 72'({resp_valid, req_ready}), 72'd0);
        @(negedge clk);
        reset = 1'b0;
        ref_err_count = 16'd0;
        repeat (3) @(negedge clk);
        check("no_resp_after_reset", 72'({resp_valid, req_ready}), 72'b01);
        check("discarded_write", 72'(n_wr_strobe - wr0), 72'd0);
        check("discarded_read", 72'(n_rd_strobe - rd0), 72'd0);
        check("err_count_cleared", 72'(err_count), 72'd0);
        run_req(1'b0, a, 64'd0, 5'd22, 0);

        // saturation of the error counter
        force dut.err_count = 16'hFFFE;
        #1;
        release dut.err_count;
        ref_err_count = 16'hFFFE;
        run_req(1'b1, 64'h500, 64'd1, 5'd1, 0);
        run_req(1'b0, 64'hFFFF_0000, 64'd0, 5'd2, 0);
        run_req(1'b0, 64'd2000, 64'd0, 5'd3, 1);

        check("no_double_strobe", 72'(both_seen), 72'd0);
        check("scoreboard_drained", 72'(exp_q.size()), 72'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    // Global time bound so the run always ends.
    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
